// File: rtl/pal_pkg.sv
// Shared definitions for the PAL configuration loader: FSM states, default
// chain length and the bytes-per-load calculation.
package pal_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_CHECK,
        S_DONE,
        S_ERROR
    } pal_state_e;

    localparam int PAL_CHAIN_LEN = 160;

    function automatic int pal_nbytes(input int chain_len);
        return (chain_len + 7) / 8;
    endfunction

    localparam int PAL_NBYTES = pal_nbytes(PAL_CHAIN_LEN);

endpackage

// File: rtl/pal_cfg_shreg.sv
// Byte-wide load/shift register feeding the fuse chain MSB first, with a
// count of bits already shifted out of the current byte.
module pal_cfg_shreg (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       shift_i,
    input  logic [7:0] data_i,
    output logic       bit_o,
    output logic [2:0] cnt_o
);

    logic [7:0] sr_q;
    logic [2:0] cnt_q;

    always_ff @(posedge clk) begin
        if (load_i) begin
            sr_q <= data_i;
        end else if (shift_i) begin
            sr_q <= {sr_q[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 3'd0;
        end else if (load_i) begin
            cnt_q <= 3'd0;
        end else if (shift_i) begin
            cnt_q <= cnt_q + 3'd1;
        end
    end

    assign bit_o = sr_q[7];
    assign cnt_o = cnt_q;

endmodule

// File: rtl/pal_cfg_loader.sv
// PAL fuse-chain configuration loader: accepts host bytes, shifts them into
// the fuse chain MSB first and validates a trailing XOR checksum byte.
module pal_cfg_loader
    import pal_pkg::*;
#(
    parameter int CHAIN_LEN = PAL_CHAIN_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_start,
    input  logic       cfg_abort,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       chain_en,
    output logic       chain_bit,
    output logic       pal_en,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int NBYTES = pal_nbytes(CHAIN_LEN);
    localparam int CW     = $clog2(NBYTES * 8 + 1);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

    pal_state_e    state_q, state_d;
    logic [CW-1:0] tot_q;
    logic [7:0]    csum_q;
    logic          xfer, start_ok, last_bit, byte_end;
    logic          sr_bit;
    logic [2:0]    sr_cnt;

    assign xfer     = byte_valid & byte_ready;
    assign start_ok = cfg_start & ~busy & ~cfg_abort;
    assign last_bit = (tot_q == LAST);
    // A byte ends after 8 bits, or early when the chain is full (partial tail byte).
    assign byte_end = (sr_cnt == 3'd7) || last_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: if (cfg_start) state_d = S_LOAD;
            S_LOAD:  if (xfer) state_d = S_SHIFT;
            S_SHIFT: if (byte_end) state_d = last_bit ? S_CHECK : S_LOAD;
            S_CHECK: if (xfer) state_d = (byte_data == csum_q) ? S_DONE : S_ERROR;
            default: state_d = S_IDLE;
        endcase
        if (cfg_abort) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        byte_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
        chain_en   = (state_q == S_SHIFT);
        chain_bit  = chain_en & sr_bit;
        busy       = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_CHECK);
        done       = (state_q == S_DONE);
        pal_en     = (state_q == S_DONE);
        err        = (state_q == S_ERROR);
    end

    // Low bits of a partial tail byte are never shifted but still enter the checksum.
    always_ff @(posedge clk) begin
        if (rst || cfg_abort || start_ok) begin
            tot_q  <= '0;
            csum_q <= 8'd0;
        end else begin
            if (state_q == S_LOAD && xfer) begin
                csum_q <= csum_q ^ byte_data;
            end
            if (chain_en) begin
                tot_q <= tot_q + 1'b1;
            end
        end
    end

    pal_cfg_shreg u_shreg (
        .clk     (clk),
        .rst     (rst),
        .load_i  ((state_q == S_LOAD) & xfer & ~cfg_abort),
        .shift_i (chain_en),
        .data_i  (byte_data),
        .bit_o   (sr_bit),
        .cnt_o   (sr_cnt)
    );

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Bench for pal_cfg_loader with a 20-bit chain: table vectors, random loads
// against a chain/checksum model, and abort/reset/stall sequences.
module tb_pal_cfg_loader;

    localparam int CL = 20;

    logic       clk = 1'b0;
    logic       rst, cfg_start, cfg_abort, byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready, chain_en, chain_bit, pal_en, busy, done, err;

    int checks = 0;
    int errors = 0;
    int stall_bad;
    logic cap_bits[$];

    always #5 clk = ~clk;

    pal_cfg_loader #(.CHAIN_LEN(CL)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .cfg_abort  (cfg_abort),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .chain_en   (chain_en),
        .chain_bit  (chain_bit),
        .pal_en     (pal_en),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always @(negedge clk) begin
        if (chain_en) cap_bits.push_back(chain_bit);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [23:0] data;
        logic [7:0]  cs;
        int          stall;
        logic        exp_done;
        logic [19:0] exp_bits;
    } vec_t;

    vec_t tbl[3];

    // The chain receives the first CL bits of the byte stream, MSB first.
    function automatic logic [19:0] model_bits(input logic [23:0] d);
        return d[23:24-CL];
    endfunction

    function automatic logic [7:0] model_cs(input logic [23:0] d);
        return d[23:16] ^ d[15:8] ^ d[7:0];
    endfunction

    function automatic logic [31:0] cap_val();
        logic [31:0] v = 0;
        foreach (cap_bits[i]) v = {v[30:0], cap_bits[i]};
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!byte_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check({nm, "_ready_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int stall);
        wait_ready("send");
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (chain_en !== 1'b0 || byte_ready !== 1'b1) stall_bad++;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic run_load(input logic [23:0] d, input logic [7:0] cs, input int stall);
        cap_bits.delete();
        stall_bad = 0;
        pulse_start();
        check("start_clears", {busy, done, err, pal_en}, 4'b1000);
        send_byte(d[23:16], stall);
        send_byte(d[15:8], stall);
        send_byte(d[7:0], stall);
        send_byte(cs, stall);
    endtask

    task automatic check_result(input string nm, input logic exp_done, input logic [19:0] exp_bits);
        check({nm, "_nbits"}, cap_bits.size(), CL);
        check({nm, "_bits"}, cap_val(), {12'd0, exp_bits});
        check({nm, "_flags"}, {done, err, pal_en, busy}, {exp_done, ~exp_done, exp_done, 1'b0});
        check({nm, "_stall_chain"}, stall_bad, 0);
    endtask

    initial begin
        logic [23:0] d;
        logic [7:0]  cs;
        logic        good;
        int          stall;

        tbl[0] = '{24'hA53CF0, 8'h69, 0, 1'b1, 20'b1010_0101_0011_1100_1111};
        tbl[1] = '{24'hA53CF0, 8'h00, 0, 1'b0, 20'b1010_0101_0011_1100_1111};
        tbl[2] = '{24'hA53CF0, 8'h69, 10, 1'b1, 20'b1010_0101_0011_1100_1111};

        rst = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {byte_ready, chain_en, chain_bit, pal_en, busy, done, err}, 7'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_outputs", {byte_ready, chain_en, pal_en, busy, done, err}, 6'd0);

        for (int i = 0; i < 3; i++) begin
            run_load(tbl[i].data, tbl[i].cs, tbl[i].stall);
            check_result($sformatf("vec%0d", i), tbl[i].exp_done, tbl[i].exp_bits);
        end

        // DONE flags persist while nothing happens.
        repeat (5) @(posedge clk);
        #1;
        check("done_sticky", {done, pal_en, busy}, 3'b110);

        for (int i = 0; i < 8; i++) begin
            d     = 24'($urandom);
            good  = 1'($urandom_range(0, 1));
            cs    = good ? model_cs(d) : (model_cs(d) ^ 8'($urandom_range(1, 255)));
            stall = $urandom_range(0, 3);
            run_load(d, cs, stall);
            check_result($sformatf("rnd%0d", i), good, model_bits(d));
        end

        // Abort during the second byte's shift, together with start and a valid byte.
        cap_bits.delete();
        pulse_start();
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0);
        @(posedge clk); #1;
        check("abort_in_shift", chain_en, 1'b1);
        cfg_abort = 1'b1; cfg_start = 1'b1; byte_valid = 1'b1; byte_data = 8'hF0;
        @(posedge clk); #1;
        cfg_abort = 1'b0; cfg_start = 1'b0; byte_valid = 1'b0;
        check("abort_idle", {busy, done, err, pal_en, chain_en, byte_ready}, 6'd0);
        @(posedge clk); #1;
        check("abort_stays_idle", {busy, byte_ready}, 2'd0);
        stall_bad = 0;
        run_load(24'hA53CF0, 8'h69, 0);
        check_result("after_abort", 1'b1, 20'hA53CF);

        cfg_abort = 1'b1;
        @(posedge clk); #1;
        cfg_abort = 1'b0;
        check("abort_from_done", {done, pal_en, err, busy}, 4'd0);

        // Start during a load is ignored; reset in CHECK overrides a valid checksum.
        cap_bits.delete();
        pulse_start();
        send_byte(8'hA5, 0);
        pulse_start();
        send_byte(8'h3C, 0);
        send_byte(8'hF0, 0);
        wait_ready("check_state");
        check("ignored_start_nbits", cap_bits.size(), CL);
        check("in_check", {busy, byte_ready, chain_en}, 3'b110);
        rst = 1'b1; byte_valid = 1'b1; byte_data = 8'h69; cfg_start = 1'b1;
        @(posedge clk); #1;
        check("reset_mid_load", {byte_ready, chain_en, chain_bit, pal_en, busy, done, err}, 7'd0);
        rst = 1'b0; byte_valid = 1'b0; cfg_start = 1'b0;
        @(posedge clk); #1;
        check("after_reset_idle", {busy, done, err, pal_en}, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pal_cfg_loader.md
PAL_CFG_LOADER -- requirements
Module: pal_cfg_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 160: number of PAL fuse bits in the configuration chain, range 8..1024.
REQ-002 SHALL have derived constant NBYTES = ceil(CHAIN_LEN/8): data bytes per load.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cfg_start  in  1  one-cycle request to begin a load.
REQ-006 cfg_abort  in  1  cancel the current load.
REQ-007 byte_valid  in  1  host byte present on byte_data.
REQ-008 byte_data  in  8  host configuration or checksum byte.
REQ-009 byte_ready  out  1  loader accepts byte this cycle.
REQ-010 chain_en  out  1  PAL fuse-chain shift enable.
REQ-011 chain_bit  out  1  fuse bit, valid when chain_en=1.
REQ-012 pal_en  out  1  PAL outputs enabled (configuration valid).
REQ-013 busy  out  1  load in progress.
REQ-014 done  out  1  last load succeeded (sticky).
REQ-015 err  out  1  last load failed checksum (sticky).

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, SHIFT, CHECK, DONE, ERROR.
REQ-017 IDLE/DONE/ERROR: cfg_start=1 -> LOAD; clear done, err, pal_en, bit counter, checksum the next cycle.
REQ-018 A byte SHALL transfer only on a cycle with byte_valid=1 and byte_ready=1; byte_ready=1 only in LOAD and CHECK.
REQ-019 LOAD: on transfer, latch byte, XOR into 8-bit checksum, -> SHIFT the next cycle.
REQ-020 SHIFT: one bit per cycle, MSB first, chain_en=1, chain_bit = current bit; chain_en=0 in all other states.
REQ-021 SHIFT SHALL emit 8 bits per byte, except the final data byte emits CHAIN_LEN mod 8 bits when that is nonzero; unshifted low bits still count in the checksum.
REQ-022 After each byte's last bit: total bits < CHAIN_LEN -> LOAD; total = CHAIN_LEN -> CHECK.
REQ-023 CHECK: on transfer, byte equal to accumulated XOR -> DONE, else -> ERROR.
REQ-024 DONE: pal_en=1 and done=1 until the next cfg_start, cfg_abort, or rst.
REQ-025 ERROR: err=1 and pal_en=0.
REQ-026 busy=1 exactly in LOAD, SHIFT, CHECK.
REQ-027 cfg_start while busy SHALL be ignored.
REQ-028 cfg_abort in any state -> IDLE next cycle with pal_en, done, err cleared; cfg_abort wins over simultaneous cfg_start or byte transfer.
REQ-029 Host stall (byte_valid=0) in LOAD or CHECK SHALL hold state indefinitely with no timeout.
REQ-030 Bit counter SHALL be wide enough for CHAIN_LEN with no wrap.

Reset
REQ-031 rst=1 SHALL force IDLE in the following cycle, including mid-load; it overrides every other input.
REQ-032 Reset values: byte_ready=0, chain_en=0, chain_bit=0, pal_en=0, busy=0, done=0, err=0; counters and checksum zero.

Structure
REQ-033 Shared package pal_pkg SHALL hold the FSM state enum, the default CHAIN_LEN, and the NBYTES calculation.
REQ-034 One sub-module pal_cfg_shreg (8-bit load/shift register with bit count) SHALL hold the SHIFT datapath; the FSM stays in pal_cfg_loader.

Verification (CHAIN_LEN=20, NBYTES=3)
REQ-035 Nominal: start, bytes A5,3C,F0, checksum 69 -> chain bits 10100101 00111100 1111 (20 chain_en pulses), done=1, pal_en=1.
REQ-036 Bad checksum: same data, checksum 00 -> err=1, pal_en=0, done=0.
REQ-037 Stall: byte_valid low 10 cycles between bytes -> chain_en stays 0 throughout; result identical to REQ-035.
REQ-038 Abort: cfg_abort during second byte's SHIFT -> IDLE next cycle, busy=0, flags clear; a new full load then succeeds.
REQ-039 Reset mid-load: rst during CHECK -> all outputs at REQ-032 values the following cycle; cfg_start during a load is ignored (bit count still 20).
